seq_gen: RTL

SEQ_GEN -- requirements
Module: seq_gen

---
 rtl/seq_gen.sv | 131 +++++++++++++
 1 files changed

// File: rtl/seq_gen.sv
// seq_gen: loads a WIDTH-bit payload on an accepted start and streams it
// MSB first on a registered serial output, with back-to-back frame chaining
// when start is presented in the done cycle.
// Optional feature: define SEQ_GEN_PREAMBLE_EN to prepend the 3-bit marker
// 1,0,1 to every frame (adds the PRE state).
module seq_gen #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  output logic             out,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  // Counter value while the last payload bit is on out.
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);
  // Counter value while the second-to-last payload bit is on out.
  localparam logic [CW-1:0] PEN_IDX  = CW'(WIDTH - 2);
`ifdef SEQ_GEN_PREAMBLE_EN
  // Counter value while the final marker bit is on out.
  localparam logic [CW-1:0] PRE_LAST = CW'(2);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shift_r;
  logic [CW-1:0]    cnt_r;
  logic             out_r;
  logic             valid_r;
  logic             busy_r;
  logic             done_r;
  logic             accept_s;

  // A start is honoured only when idle or while the last bit of a frame is out.
  always_comb begin
    accept_s = 1'b0;
    if (start && ((state_r == IDLE) || done_r)) begin
      accept_s = 1'b1;
    end else begin
      accept_s = 1'b0;
    end
  end

  // Frame FSM: shift register, bit counter and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      shift_r <= '0;
      cnt_r   <= '0;
      out_r   <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      shift_r <= pattern;
      cnt_r   <= '0;
      valid_r <= 1'b1;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
`ifdef SEQ_GEN_PREAMBLE_EN
      state_r <= PRE;
      out_r   <= 1'b1;
`else
      state_r <= DATA;
      out_r   <= pattern[WIDTH-1];
`endif
    end else begin
      case (state_r)
        IDLE: begin
          out_r   <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
`ifdef SEQ_GEN_PREAMBLE_EN
        PRE: begin
          done_r <= 1'b0;
          if (cnt_r == PRE_LAST) begin
            state_r <= DATA;
            cnt_r   <= '0;
            out_r   <= shift_r[WIDTH-1];
          end else begin
            // Marker is 1,0,1: after bit 0 comes 0, after bit 1 comes 1.
            cnt_r <= cnt_r + CW'(1);
            out_r <= cnt_r[0];
          end
        end
`endif
        DATA: begin
          if (cnt_r == LAST_IDX) begin
            // Last bit just went out and nothing chained: drop back to idle.
            state_r <= IDLE;
            out_r   <= 1'b0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CW'(1);
            shift_r <= {shift_r[WIDTH-2:0], 1'b0};
            out_r   <= shift_r[WIDTH-2];
            done_r  <= (cnt_r == PEN_IDX);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          out_r   <= 1'b0;
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_r;
  assign out_valid = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule
